// File: rtl/g_reg_sb_pkg.sv
// Register scoreboard shared definitions: default parameters and width helpers.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
//
// Used by g_reg_sb and g_reg_sb_entry. Optional feature macro: G_REG_SB_BYPASS_EN
// (handled in g_reg_sb; nothing in this package depends on it).
package g_reg_sb_pkg;

  // Default configuration of the scoreboard.
  localparam int G_REG_SB_W_OPR_DEF    = 32;
  localparam int G_REG_SB_N_REG_DEF    = 16;
  localparam int G_REG_SB_N_RP_DEF     = 2;
  localparam int G_REG_SB_MAX_PEND_DEF = 3;

  // Ceiling log2; returns 0 for val <= 1.
  function automatic int f_clog2(input int val);
    int res;
    res = 0;
    while ((1 << res) < val) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Register-address width for a power-of-two register count.
  function automatic int f_w_rd(input int n_reg);
    return f_clog2(n_reg);
  endfunction

  // Pending-counter width: must hold the values 0..max_pend inclusive.
  function automatic int f_w_pend(input int max_pend);
    return f_clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/g_reg_sb_entry.sv
// One scoreboard entry: data word plus saturating-free pending-reservation counter.
// Latency: data and counter update at the rising edge after the request; outputs are the stored state.
// Backpressure: none here; the top only presents reserves that fit below MAX_PEND.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   rsv_i             accepted reservation aimed at this entry
//   wb_i              writeback aimed at this entry
//   flush_i           clear the pending counter
//   result_i          writeback data
//   data_o, pend_o    stored data word and pending count
module g_reg_sb_entry
  import g_reg_sb_pkg::*;
#(
  parameter int W_OPR  = G_REG_SB_W_OPR_DEF,
  parameter int W_PEND = f_w_pend(G_REG_SB_MAX_PEND_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rsv_i,
  input  logic              wb_i,
  input  logic              flush_i,
  input  logic [W_OPR-1:0]  result_i,
  output logic [W_OPR-1:0]  data_o,
  output logic [W_PEND-1:0] pend_o
);

  logic [W_OPR-1:0]  data_q, data_d;
  logic [W_PEND-1:0] pend_q, pend_d;

  // Data always follows a writeback, even during a flush or with no reservation.
  always_comb begin
    data_d = data_q;
    if (wb_i) begin
      data_d = result_i;
    end
  end

  // A reserve and a writeback in the same cycle cancel out. A writeback with no
  // reservation leaves the count at zero (the top flags that as an error).
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else if (rsv_i && !wb_i) begin
      pend_d = pend_q + W_PEND'(1);
    end else if (wb_i && !rsv_i && (pend_q != '0)) begin
      pend_d = pend_q - W_PEND'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      pend_q <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign data_o = data_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/g_reg_sb.sv
// Register scoreboard: register file with per-register pending-write counters and N_RP read ports.
// Latency: reads and w_full_o are combinational; reserve/writeback/flush take effect at the next edge.
// Backpressure: w_full_o high means a reserve of w_reserve_r_i is dropped this cycle; no other stalls.
//
// Ports:
//   clk, reset                    rising-edge clock, asynchronous active-low reset
//   w_reserve_i, w_reserve_r_i    reservation request and target register
//   w_full_o                      target register already holds MAX_PEND reservations
//   r_i, r_opr_o, reserved_o      flattened read addresses / data / busy flags, port k at [k*W +: W]
//   wb_i, wb_r_i, result_i        writeback valid, register, data
//   flush_i                       drop every reservation
//   err_o                         sticky: writeback hit a register with no reservation
//
// Optional feature: define G_REG_SB_BYPASS_EN to forward a same-cycle writeback to
// matching read ports (data and post-update busy flag). Without it reads see stored state only.
module g_reg_sb
  import g_reg_sb_pkg::*;
#(
  parameter int W_OPR    = G_REG_SB_W_OPR_DEF,
  parameter int N_REG    = G_REG_SB_N_REG_DEF,
  parameter int N_RP     = G_REG_SB_N_RP_DEF,
  parameter int MAX_PEND = G_REG_SB_MAX_PEND_DEF,
  localparam int W_RD    = f_w_rd(N_REG),
  localparam int W_PEND  = f_w_pend(MAX_PEND)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_reserve_i,
  input  logic [W_RD-1:0]       w_reserve_r_i,
  output logic                  w_full_o,
  input  logic [N_RP*W_RD-1:0]  r_i,
  output logic [N_RP*W_OPR-1:0] r_opr_o,
  output logic [N_RP-1:0]       reserved_o,
  input  logic                  wb_i,
  input  logic [W_RD-1:0]       wb_r_i,
  input  logic [W_OPR-1:0]      result_i,
  input  logic                  flush_i,
  output logic                  err_o
);

  logic [W_OPR-1:0]  ent_data [N_REG];
  logic [W_PEND-1:0] ent_pend [N_REG];

  logic rsv_acc;
  logic err_q, err_d;

  // Fullness looks at the stored count only, so a writeback in the same cycle
  // does not make room for a reserve.
  assign w_full_o = (ent_pend[w_reserve_r_i] == W_PEND'(MAX_PEND));
  assign rsv_acc  = w_reserve_i && !w_full_o && !flush_i;

  for (genvar g = 0; g < N_REG; g++) begin : g_ent
    g_reg_sb_entry #(
      .W_OPR  (W_OPR),
      .W_PEND (W_PEND)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .rsv_i    (rsv_acc && (w_reserve_r_i == W_RD'(g))),
      .wb_i     (wb_i && (wb_r_i == W_RD'(g))),
      .flush_i  (flush_i),
      .result_i (result_i),
      .data_o   (ent_data[g]),
      .pend_o   (ent_pend[g])
    );
  end

  // Sticky error; a flush does not clear it, only reset does.
  always_comb begin
    err_d = err_q;
    if (wb_i && (ent_pend[wb_r_i] == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef G_REG_SB_BYPASS_EN
  // Busy flag of the writeback register after this edge: flush empties it; a
  // matching accepted reserve cancels the writeback; otherwise the count drops
  // by one (or stays at zero).
  logic wb_rsvd_nxt;
  assign wb_rsvd_nxt = !flush_i &&
                       ((rsv_acc && (w_reserve_r_i == wb_r_i)) ? (ent_pend[wb_r_i] != '0)
                                                               : (ent_pend[wb_r_i] > W_PEND'(1)));
`endif

  for (genvar k = 0; k < N_RP; k++) begin : g_rd
    logic [W_RD-1:0] addr;
    assign addr = r_i[k*W_RD +: W_RD];
`ifdef G_REG_SB_BYPASS_EN
    logic byp_hit;
    assign byp_hit = wb_i && (addr == wb_r_i);
    assign r_opr_o[k*W_OPR +: W_OPR] = byp_hit ? result_i : ent_data[addr];
    assign reserved_o[k]             = byp_hit ? wb_rsvd_nxt : (ent_pend[addr] != '0);
`else
    assign r_opr_o[k*W_OPR +: W_OPR] = ent_data[addr];
    assign reserved_o[k]             = (ent_pend[addr] != '0);
`endif
  end

endmodule

// File: tb/tb_g_reg_sb.sv
// Self-checking bench for g_reg_sb: directed scenarios followed by randomized traffic,
// all compared against a count/data model of the scoreboard rules.
module tb_g_reg_sb;

  localparam int W_OPR    = 32;
  localparam int N_REG    = 16;
  localparam int N_RP     = 2;
  localparam int MAX_PEND = 3;
  localparam int W_RD     = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  w_reserve_i;
  logic [W_RD-1:0]       w_reserve_r_i;
  logic                  w_full_o;
  logic [N_RP*W_RD-1:0]  r_i;
  logic [N_RP*W_OPR-1:0] r_opr_o;
  logic [N_RP-1:0]       reserved_o;
  logic                  wb_i;
  logic [W_RD-1:0]       wb_r_i;
  logic [W_OPR-1:0]      result_i;
  logic                  flush_i;
  logic                  err_o;

  always #5 clk = ~clk;

  g_reg_sb #(
    .W_OPR    (W_OPR),
    .N_REG    (N_REG),
    .N_RP     (N_RP),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .w_reserve_i   (w_reserve_i),
    .w_reserve_r_i (w_reserve_r_i),
    .w_full_o      (w_full_o),
    .r_i           (r_i),
    .r_opr_o       (r_opr_o),
    .reserved_o    (reserved_o),
    .wb_i          (wb_i),
    .wb_r_i        (wb_r_i),
    .result_i      (result_i),
    .flush_i       (flush_i),
    .err_o         (err_o)
  );

  int checks   = 0;
  int failures = 0;

  // Model state (current) and state after the coming edge.
  logic [W_OPR-1:0] m_data [N_REG];
  int               m_pend [N_REG];
  bit               m_err;
  logic [W_OPR-1:0] n_data [N_REG];
  int               n_pend [N_REG];
  bit               n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_REG; i++) begin
      m_data[i] = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle();
    w_reserve_i   = 1'b0;
    w_reserve_r_i = '0;
    wb_i          = 1'b0;
    wb_r_i        = '0;
    result_i      = '0;
    flush_i       = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    r_i = {W_RD'(a1), W_RD'(a0)};
  endtask

  // Settle the current inputs, predict the post-edge state, check combinational outputs.
  task automatic check_comb(input string tag);
    bit               full_e;
    bit               acc;
    int               a;
    int               c;
    logic [W_OPR-1:0] exp_d;
    bit               exp_r;
    #1;
    full_e = (m_pend[int'(w_reserve_r_i)] == MAX_PEND);
    acc    = w_reserve_i && !full_e && !flush_i;
    n_err  = m_err;
    for (int i = 0; i < N_REG; i++) begin
      n_data[i] = m_data[i];
      c = m_pend[i];
      if (flush_i) c = 0;
      else begin
        if (acc && int'(w_reserve_r_i) == i) c = c + 1;
        if (wb_i && int'(wb_r_i) == i) c = (c > 0) ? c - 1 : 0;
        if (acc && wb_i && int'(w_reserve_r_i) == i && int'(wb_r_i) == i) c = m_pend[i];
      end
      n_pend[i] = c;
    end
    if (wb_i) begin
      n_data[int'(wb_r_i)] = result_i;
      if (m_pend[int'(wb_r_i)] == 0) n_err = 1'b1;
    end
    chk({tag, "/full"}, 64'(w_full_o), 64'(full_e));
    chk({tag, "/err"}, 64'(err_o), 64'(m_err));
    for (int k = 0; k < N_RP; k++) begin
      a     = int'(r_i[k*W_RD +: W_RD]);
      exp_d = m_data[a];
      exp_r = (m_pend[a] != 0);
`ifdef G_REG_SB_BYPASS_EN
      if (wb_i && a == int'(wb_r_i)) begin
        exp_d = result_i;
        exp_r = (n_pend[a] != 0);
      end
`endif
      chk($sformatf("%s/opr%0d", tag, k), 64'(r_opr_o[k*W_OPR +: W_OPR]), 64'(exp_d));
      chk($sformatf("%s/rsvd%0d", tag, k), 64'(reserved_o[k]), 64'(exp_r));
    end
  endtask

  task automatic clock_step();
    @(posedge clk);
    for (int i = 0; i < N_REG; i++) begin
      m_data[i] = n_data[i];
      m_pend[i] = n_pend[i];
    end
    m_err = n_err;
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    check_comb(tag);
    clock_step();
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    idle();
    set_rd(1, 1);
    model_reset();
    #12;
    chk("rst_opr", 64'(r_opr_o), 64'd0);
    chk("rst_rsvd", 64'(reserved_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_full", 64'(w_full_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Read r1 after reset
    check_comb("rd_r1");
    chk("rd_r1_opr", 64'(r_opr_o[W_OPR-1:0]), 64'd0);
    chk("rd_r1_rsvd", 64'(reserved_o[0]), 64'd0);
    chk("rd_r1_err", 64'(err_o), 64'd0);
    clock_step();

    // Fill r2 to MAX_PEND, then a rejected fourth reserve
    set_rd(2, 2);
    w_reserve_i   = 1'b1;
    w_reserve_r_i = 4'd2;
    for (int n = 0; n < 3; n++) step("rsv_r2");
    check_comb("rsv_r2_4th");
    chk("full_at_max", 64'(w_full_o), 64'd1);
    clock_step();
    w_reserve_i = 1'b0;
    check_comb("r2_still_full");
    chk("r2_cnt_stays_max", 64'(w_full_o), 64'd1);
    clock_step();
    wb_i = 1'b1; wb_r_i = 4'd2; result_i = 32'h89abcdef;
    step("wb_r2");
    idle();
    w_reserve_r_i = 4'd2;
    check_comb("after_wb_r2");
    chk("r2_data", 64'(r_opr_o[W_OPR-1:0]), 64'h89abcdef);
    chk("r2_not_full", 64'(w_full_o), 64'd0);
    chk("r2_rsvd", 64'(reserved_o[0]), 64'd1);
    clock_step();
    // Count must be 2: one more reserve fills it again
    w_reserve_i = 1'b1;
    step("rsv_r2_again");
    idle();
    w_reserve_r_i = 4'd2;
    check_comb("r2_refull");
    chk("r2_cnt_was_2", 64'(w_full_o), 64'd1);
    clock_step();
    // Two writebacks bring r2 to count 1
    wb_i = 1'b1; wb_r_i = 4'd2; result_i = 32'haaaa0001;
    step("wb_r2_a");
    result_i = 32'haaaa0002;
    step("wb_r2_b");
    idle();

    // Reserve and writeback r5 in the same cycle with count 1
    w_reserve_i = 1'b1; w_reserve_r_i = 4'd5;
    step("rsv_r5");
    wb_i = 1'b1; wb_r_i = 4'd5; result_i = 32'h55550005;
    step("rsv_wb_r5");
    idle();
    set_rd(5, 5);
    check_comb("r5_after");
    chk("r5_rsvd_both", 64'(reserved_o), 64'd3);
    chk("r5_opr_p0", 64'(r_opr_o[W_OPR-1:0]), 64'h55550005);
    chk("r5_opr_p1", 64'(r_opr_o[2*W_OPR-1:W_OPR]), 64'h55550005);
    clock_step();

    // Writeback to r2 (count 1) while port 0 reads r2
    set_rd(2, 2);
    wb_i = 1'b1; wb_r_i = 4'd2; result_i = 32'h12345678;
    check_comb("byp_r2");
`ifdef G_REG_SB_BYPASS_EN
    chk("byp_opr", 64'(r_opr_o[W_OPR-1:0]), 64'h12345678);
    chk("byp_rsvd", 64'(reserved_o[0]), 64'd0);
`else
    chk("nobyp_opr", 64'(r_opr_o[W_OPR-1:0]), 64'haaaa0002);
    chk("nobyp_rsvd", 64'(reserved_o[0]), 64'd1);
`endif
    clock_step();
    idle();
    check_comb("r2_settled");
    chk("r2_new_data", 64'(r_opr_o[W_OPR-1:0]), 64'h12345678);
    chk("r2_idle", 64'(reserved_o[0]), 64'd0);
    clock_step();

    // Writeback to r7 with no reservation -> sticky error
    wb_i = 1'b1; wb_r_i = 4'd7; result_i = 32'h77770007;
    step("wb_r7_err");
    idle();
    check_comb("err_set");
    chk("err_set", 64'(err_o), 64'd1);
    clock_step();
    for (int n = 0; n < 3; n++) step("idle");
    chk("err_sticky", 64'(err_o), 64'd1);

    // Flush with r3 at count 2 plus same-cycle reserve of r3
    w_reserve_i = 1'b1; w_reserve_r_i = 4'd3;
    step("rsv_r3");
    step("rsv_r3");
    flush_i = 1'b1;
    step("flush_rsv_r3");
    idle();
    set_rd(3, 5);
    w_reserve_r_i = 4'd3;
    check_comb("after_flush");
    chk("r3_cleared", 64'(reserved_o[0]), 64'd0);
    chk("r5_cleared", 64'(reserved_o[1]), 64'd0);
    chk("err_kept", 64'(err_o), 64'd1);
    clock_step();

    // Randomized traffic, biased to a few registers to create collisions
    for (int n = 0; n < 400; n++) begin
      w_reserve_i   = ($urandom_range(0, 2) != 0);
      w_reserve_r_i = W_RD'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      wb_i          = ($urandom_range(0, 1) != 0);
      wb_r_i        = W_RD'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      result_i      = $urandom;
      flush_i       = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) set_rd(int'(wb_r_i), int'(wb_r_i));
      else set_rd($urandom_range(0, 3), $urandom_range(0, 3));
      step("rnd");
    end

    // Reset asserted mid-operation: reserve some registers, then reset between edges
    idle();
    w_reserve_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      w_reserve_r_i = W_RD'(n);
      step("pre_rst");
    end
    idle();
    set_rd(0, 1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_opr", 64'(r_opr_o), 64'd0);
    chk("mid_rst_rsvd", 64'(reserved_o), 64'd0);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    chk("mid_rst_full", 64'(w_full_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 60; n++) begin
      w_reserve_i   = ($urandom_range(0, 1) != 0);
      w_reserve_r_i = W_RD'($urandom_range(0, 3));
      wb_i          = ($urandom_range(0, 1) != 0);
      wb_r_i        = W_RD'($urandom_range(0, 3));
      result_i      = $urandom;
      flush_i       = 1'b0;
      set_rd($urandom_range(0, 3), $urandom_range(0, 3));
      step("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/g_reg_sb.md
G_REG_SB -- requirements
Module: g_reg_sb

Interface
REQ-001 The block SHALL have parameter W_OPR, default 32, data word width.
REQ-002 The block SHALL have parameter N_REG, default 16, register count (power of two, >=2); W_RD = clog2(N_REG).
REQ-003 The block SHALL have parameter N_RP, default 2, number of read ports.
REQ-004 The block SHALL have parameter MAX_PEND, default 3, maximum outstanding reservations per register (1..7).
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 w_reserve_i  input  1  request to reserve register w_reserve_r_i.
REQ-008 w_reserve_r_i  input  W_RD  register to reserve.
REQ-009 w_full_o  output  1  reservation count of w_reserve_r_i equals MAX_PEND, combinational.
REQ-010 r_i  input  N_RP*W_RD  flattened read addresses; port k is bits [k*W_RD +: W_RD].
REQ-011 r_opr_o  output  N_RP*W_OPR  flattened read data, same packing.
REQ-012 reserved_o  output  N_RP  per-port: addressed register has a nonzero reservation count.
REQ-013 wb_i  input  1  writeback valid.
REQ-014 wb_r_i  input  W_RD  writeback register; result_i  input  W_OPR  writeback data.
REQ-015 flush_i  input  1  clear all reservations (pipeline flush on branch).
REQ-016 err_o  output  1  sticky: writeback to a register whose count was 0.

Function
REQ-017 Each register SHALL hold a data word and a pending counter pend[r] of clog2(MAX_PEND+1) bits.
REQ-018 Reads SHALL be combinational: r_opr_o port k = data[r_i[k]], reserved_o[k] = (pend[r_i[k]] != 0).
REQ-019 With wb_i high, data[wb_r_i] SHALL take result_i at the next rising edge.
REQ-020 Counter update per register per edge: +1 if accepted reserve only, -1 if writeback only (when pend>0), unchanged if both or neither.
REQ-021 A reserve SHALL be accepted only when w_reserve_i is high, w_full_o is low and flush_i is low; a rejected reserve changes nothing.
REQ-022 w_full_o SHALL depend on the current count only, not on a same-cycle writeback.
REQ-023 Writeback with pend[wb_r_i]==0 SHALL write data, leave count at 0 and set err_o from the next edge until reset.
REQ-024 flush_i high SHALL zero every counter at the next edge; a same-cycle writeback still writes its data; err_o is unaffected.
REQ-025 Multiple read ports addressing the same register SHALL return identical values.

Reset
REQ-026 Asserting reset (low) SHALL immediately clear all data words, all counters and err_o to 0; w_full_o and reserved_o then read 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight reservations; no state persists.

Configuration
REQ-028 Macro G_REG_SB_BYPASS_EN defined: a read port whose address equals wb_r_i while wb_i is high SHALL return result_i, and its reserved_o SHALL reflect the count after this cycle's update.
REQ-029 Macro G_REG_SB_BYPASS_EN undefined: reads SHALL return stored data and current count only; writeback is visible one cycle later.

Structure
REQ-030 The W_RD derivation function and the default parameter constants SHALL live in shared package g_reg_sb_pkg.
REQ-031 The per-register counter and data word SHALL be a sub-module g_reg_sb_entry, instantiated N_REG times by generate.

Verification
REQ-032 Reset low, then high; read r1 -> r_opr_o=0, reserved_o=0, err_o=0.
REQ-033 Reserve r2 three times (MAX_PEND=3) -> w_full_o=1; fourth reserve -> count stays 3; one writeback of 32'h89abcdef to r2 -> count 2, data 89abcdef, w_full_o=0.
REQ-034 Reserve r5 and writeback r5 in the same cycle with count 1 -> count stays 1, data updated, reserved_o=1.
REQ-035 With the bypass macro: count r2=1, wb r2 with 32'h12345678 while port 0 reads r2 -> same-cycle r_opr_o=12345678, reserved_o=0; without the macro -> old data, reserved_o=1.
REQ-036 Writeback r7 with count 0 -> err_o=1 and stays 1; flush with r3 count 2 plus same-cycle reserve r3 -> count 0.
